// File: rtl/sop_eval_sweep.sv
// Programmable sum-of-products evaluator with run-time loaded terms.
// Supports single-vector evaluation with valid/ready, and an exhaustive on-set count sweep.
module sop_eval_sweep #(
   parameter int N_IN   = 7,
   parameter int N_TERM = 4,
   parameter int IDX_W  = (N_TERM > 1) ? $clog2(N_TERM) : 1,
   parameter int CNT_W  = N_IN + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic             cfg_en,
   input  logic [N_IN-1:0]  cfg_care,
   input  logic [N_IN-1:0]  cfg_pol,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_vec,
   output logic             out_valid,
   output logic             out_z,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic [CNT_W-1:0] ones_cnt
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t            state_q, state_d;
   logic [N_TERM-1:0] en_q;
   logic [N_IN-1:0]   care_q [N_TERM];
   logic [N_IN-1:0]   pol_q  [N_TERM];
   logic [N_IN-1:0]   vec_cnt_q;
   logic              f_in, f_sweep, accept, last_vec;

   // Two evaluators share the term table: one for the direct vector, one for the sweep counter.
   always_comb begin
      f_in    = 1'b0;
      f_sweep = 1'b0;
      for (int t = 0; t < N_TERM; t++) begin
         if (en_q[t] && (((in_vec ~^ pol_q[t]) & care_q[t]) == care_q[t]))
            f_in = 1'b1;
         if (en_q[t] && (((vec_cnt_q ~^ pol_q[t]) & care_q[t]) == care_q[t]))
            f_sweep = 1'b1;
      end
   end

   assign in_ready   = (state_q == IDLE) && !sweep_start;
   assign accept     = in_valid && in_ready;
   assign last_vec   = &vec_cnt_q;
   assign sweep_busy = (state_q == SWEEP);
   assign sweep_done = (state_q == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sweep_start) state_d = SWEEP;
         SWEEP:   if (last_vec)    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the term table is small and must read back as cleared after reset, so every entry is reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q <= '0;
         for (int t = 0; t < N_TERM; t++) begin
            care_q[t] <= '0;
            pol_q[t]  <= '0;
         end
      end else if (cfg_we && state_q == IDLE) begin
         // An index outside the table matches no entry and is silently dropped.
         for (int t = 0; t < N_TERM; t++) begin
            if (cfg_idx == IDX_W'(t)) begin
               en_q[t]   <= cfg_en;
               care_q[t] <= cfg_care;
               pol_q[t]  <= cfg_pol;
            end
         end
      end
   end

   // NOTE: registered state uses <= so every block samples pre-edge values, e.g. an eval
   // in the same cycle as a config write still sees the old terms.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_z     <= 1'b0;
         ones_cnt  <= '0;
         vec_cnt_q <= '0;
      end else begin
         out_valid <= accept;
         if (accept) out_z <= f_in;
         if (state_q == IDLE && sweep_start) begin
            ones_cnt  <= '0;
            vec_cnt_q <= '0;
         end else if (state_q == SWEEP) begin
            ones_cnt  <= ones_cnt + CNT_W'(f_sweep);
            vec_cnt_q <= vec_cnt_q + N_IN'(1);
         end
      end
   end

endmodule

// File: tb/tb_sop_eval_sweep.sv
// Self-checking bench for sop_eval_sweep: directed steps plus random configs and vectors
// compared against a bit-by-bit reference model of the term table.
module tb_sop_eval_sweep;

   localparam int N_IN   = 7;
   localparam int N_TERM = 4;
   localparam int IDX_W  = 3;   // wide enough to present out-of-range indices
   localparam int CNT_W  = N_IN + 1;
   localparam int NVEC   = 1 << N_IN;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_we;
   logic [IDX_W-1:0] cfg_idx;
   logic             cfg_en;
   logic [N_IN-1:0]  cfg_care, cfg_pol;
   logic             in_valid, in_ready;
   logic [N_IN-1:0]  in_vec;
   logic             out_valid, out_z;
   logic             sweep_start, sweep_busy, sweep_done;
   logic [CNT_W-1:0] ones_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model of the loaded terms.
   bit              m_en   [N_TERM];
   bit [N_IN-1:0]   m_care [N_TERM];
   bit [N_IN-1:0]   m_pol  [N_TERM];
   bit              last_z;

   sop_eval_sweep #(.N_IN(N_IN), .N_TERM(N_TERM), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_care(cfg_care), .cfg_pol(cfg_pol),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_z(out_z),
      .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
      .ones_cnt(ones_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_f(input bit [N_IN-1:0] v);
      for (int t = 0; t < N_TERM; t++) begin
         if (m_en[t]) begin
            bit hit = 1'b1;
            for (int i = 0; i < N_IN; i++)
               if (m_care[t][i] && (v[i] != m_pol[t][i])) hit = 1'b0;
            if (hit) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic int model_ones();
      int n = 0;
      for (int v = 0; v < NVEC; v++) n += int'(model_f(N_IN'(v)));
      return n;
   endfunction

   task automatic model_clear();
      for (int t = 0; t < N_TERM; t++) begin
         m_en[t] = 1'b0; m_care[t] = '0; m_pol[t] = '0;
      end
   endtask

   task automatic cfg_write(input int idx, input bit en, input bit [N_IN-1:0] care,
                            input bit [N_IN-1:0] pol);
      cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_en = en; cfg_care = care; cfg_pol = pol;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (idx < N_TERM) begin
         m_en[idx] = en; m_care[idx] = care; m_pol[idx] = pol;
      end
   endtask

   // Back-to-back evaluation of a list of vectors; one result is expected per cycle.
   task automatic eval_seq(input string tag, input bit [N_IN-1:0] vecs[$]);
      foreach (vecs[i]) begin
         in_valid = 1'b1; in_vec = vecs[i];
         @(posedge clk); #1;
         last_z = model_f(vecs[i]);
         check($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 32'd1);
         check($sformatf("%s_z%0d", tag, i), 32'(out_z), 32'(last_z));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_z_hold"}, 32'(out_z), 32'(last_z));
   endtask

   task automatic run_sweep(input string tag, input int exp_ones, input bit with_valid,
                            input bit poke_cfg);
      int busy = 0;
      int rdy_bad = 0;
      sweep_start = 1'b1;
      in_valid = with_valid; in_vec = '1;
      #1;
      check({tag, "_ready_start"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      sweep_start = 1'b0; in_valid = 1'b0;
      check({tag, "_no_outvalid"}, 32'(out_valid), 32'd0);
      while (sweep_busy && busy < 400) begin
         if (in_ready) rdy_bad++;
         busy++;
         if (poke_cfg && busy == 10) begin
            cfg_we = 1'b1; cfg_idx = '0; cfg_en = 1'b1; cfg_care = '0; cfg_pol = '0;
         end else begin
            cfg_we = 1'b0;
         end
         in_valid = (busy == 20);   // dropped: never accepted mid-sweep
         @(posedge clk); #1;
      end
      cfg_we = 1'b0; in_valid = 1'b0;
      check({tag, "_busy_cycles"}, 32'(busy), 32'(NVEC));
      check({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
      check({tag, "_done"}, 32'(sweep_done), 32'd1);
      check({tag, "_ones"}, 32'(ones_cnt), 32'(exp_ones));
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(sweep_done), 32'd0);
      check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
      check({tag, "_ones_hold"}, 32'(ones_cnt), 32'(exp_ones));
   endtask

   initial begin
      bit [N_IN-1:0] vq[$];
      rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_care = '0; cfg_pol = '0;
      in_valid = 1'b0; in_vec = '0; sweep_start = 1'b0;
      model_clear();
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_z", 32'(out_z), 32'd0);
      check("rst_busy", 32'(sweep_busy), 32'd0);
      check("rst_done", 32'(sweep_done), 32'd0);
      check("rst_ones", 32'(ones_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: empty table evaluates to 0 everywhere
      vq = '{7'h00, 7'h7F};
      eval_seq("empty", vq);
      run_sweep("empty_sweep", 0, 1'b0, 1'b0);

      // 2: directed config and hand-derived results
      cfg_write(0, 1'b1, 7'b1111000, 7'b0011000);
      cfg_write(1, 1'b1, 7'b0000101, 7'b0000001);
      cfg_write(2, 1'b1, 7'b0000011, 7'b0000011);
      vq = '{7'b0011000, 7'b1000001, 7'b0000100, 7'b1110011};
      eval_seq("dir", vq);
      check("dir_model_sane", 32'({model_f(7'b0011000), model_f(7'b1000001),
                                   model_f(7'b0000100), model_f(7'b1110011)}), 32'b1101);

      // 3: sweep of the same config
      check("dir_model_ones", 32'(model_ones()), 32'd53);
      run_sweep("dir_sweep", 53, 1'b0, 1'b0);

      // 4: single care=0 term covers every vector; out-of-range index ignored
      for (int t = 0; t < N_TERM; t++) cfg_write(t, 1'b0, '0, '0);
      cfg_write(0, 1'b1, 7'h7F, 7'h00);
      cfg_write(5, 1'b1, 7'h00, 7'h00);
      run_sweep("idx5_sweep", 1, 1'b0, 1'b0);
      cfg_write(2, 1'b1, 7'h00, 7'h00);
      run_sweep("full_sweep", NVEC, 1'b0, 1'b0);

      // Random configs and vectors against the model
      for (int r = 0; r < 3; r++) begin
         for (int t = 0; t < N_TERM; t++)
            cfg_write(t, 1'($urandom_range(0, 3) != 0), N_IN'($urandom), N_IN'($urandom));
         vq.delete();
         for (int i = 0; i < 12; i++) vq.push_back(N_IN'($urandom));
         eval_seq($sformatf("rnd%0d", r), vq);
         run_sweep($sformatf("rnd%0d_sweep", r), model_ones(), 1'b0, 1'b0);
      end

      // Same-cycle config write and eval: eval must see the old table
      cfg_write(0, 1'b1, 7'h7F, 7'h55);
      for (int t = 1; t < N_TERM; t++) cfg_write(t, 1'b0, '0, '0);
      cfg_we = 1'b1; cfg_idx = '0; cfg_en = 1'b0; cfg_care = '0; cfg_pol = '0;
      in_valid = 1'b1; in_vec = 7'h55;
      @(posedge clk); #1;
      cfg_we = 1'b0; in_valid = 1'b0;
      check("same_cycle_old_cfg", 32'(out_z), 32'd1);
      m_en[0] = 1'b0;
      check("same_cycle_model", 32'(model_f(7'h55)), 32'd0);

      // 5: config write during sweep ignored; sweep_start wins over in_valid
      cfg_write(1, 1'b1, 7'b0000011, 7'b0000010);
      run_sweep("poke_sweep", model_ones(), 1'b1, 1'b1);
      run_sweep("poke_resweep", model_ones(), 1'b0, 1'b0);

      // 6: reset mid-sweep clears everything immediately
      vq = '{7'b0000010};
      eval_seq("pre_rst", vq);
      sweep_start = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("mid_busy", 32'(sweep_busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(sweep_busy), 32'd0);
      check("abort_done", 32'(sweep_done), 32'd0);
      check("abort_ones", 32'(ones_cnt), 32'd0);
      check("abort_out_z", 32'(out_z), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_ready", 32'(in_ready), 32'd1);
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0;
      run_sweep("post_rst_sweep", 0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
